text_cursor_ctrl: RTL and testbench
===================================

// Module: text_cursor_ctrl
// PURPOSE
//   Sequences all writes into the 30x70 character screen RAM of the VGA text console.
//   Accepts decoded keystrokes over a valid/ready handshake and tracks the cursor.
//   Handles printable characters, carriage return, backspace, line wrap and row clears.
//   Also clears the whole screen on request. It is the only writer of the screen RAM.
// PARAMETERS
//   COLS   70  characters per row (cursor column range 0..COLS-1)
//   ROWS   30  rows per screen (cursor row range 0..ROWS-1)
//   COL_W  7   column index width, 2^COL_W >= COLS
//   ROW_W  5   row index width, 2^ROW_W >= ROWS
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   key_valid  in   1      key_ascii holds a keystroke
//   key_ascii  in   8      ASCII code of keystroke
//   key_ready  out  1      keystroke accepted when key_valid & key_ready at a clk edge
//   clear_all  in   1      single-cycle request: blank entire screen, cursor home
//   wr_en      out  1      screen RAM write strobe
//   wr_row     out  ROW_W  screen RAM write row
//   wr_col     out  COL_W  screen RAM write column
//   wr_data    out  8      screen RAM write data (8'h00 = blank)
//   cur_row    out  ROW_W  current cursor row
//   cur_col    out  COL_W  current cursor column
//   busy       out  1      high whenever state != IDLE
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, cursor (0,0), wr_en=0, wr_row/col/data=0,
//     clr_pend=0, busy=0. No partial clear resumes after reset.
//   key_ready = (state==IDLE) & !clr_pend, combinational.
//   clr_pend is set by clear_all in any cycle and cleared when CLEAR_ALL is entered.
//   FSM states: IDLE, CLEAR_LINE, CLEAR_ALL.
//   IDLE, accept at edge T; all outputs registered and valid from T+1:
//    - 0x20..0x7E: wr_en=1, wr_data=key_ascii, addr = old cursor. Cursor advances one column.
//      If col==COLS-1: col=0, row=row+1 (ROWS-1 wraps to 0), and next state=CLEAR_LINE.
//    - 0x0D: no char write (wr_en=0). col=0, row advances with the same wrap rule,
//      then CLEAR_LINE.
//    - 0x08: if col>0, col-1. Else if row>0: row-1, col=COLS-1. Else (0,0): no change,
//      wr_en=0. When the cursor moves: wr_en=1, wr_data=0x00 at the new cursor position.
//    - any other code (incl. 0x00, 0x0A): accepted, ignored, wr_en=0.
//    - throughput 1 key/cycle while no row change occurs.
//   IDLE with no accept and clr_pend=1: go to CLEAR_ALL.
//     A key accepted in the same cycle as clear_all is processed first.
//   CLEAR_LINE: COLS consecutive cycles, wr_en=1, wr_row=new cursor row, wr_col=0..COLS-1,
//     wr_data=0x00, then IDLE. The printable char write (T+1) precedes the clear (T+2..T+1+COLS).
//   CLEAR_ALL: ROWS*COLS consecutive cycles, row-major (0,0)..(ROWS-1,COLS-1), data 0x00.
//     Cursor is set to (0,0) on entry; then IDLE. clear_all arriving during CLEAR_ALL
//     re-sets clr_pend, so the clear repeats once.
//   wr_en=0 in every cycle not listed above. Column/row counters never exceed COLS-1/ROWS-1.
// TESTING
//   1 reset, send 'h','i' back-to-back -> writes (0,0)=0x68,(0,1)=0x69 on consecutive
//     cycles; cursor (0,2); key_ready stays 1.
//   2 cursor (3,69), send 'A' -> write (3,69)=0x41, then 70 writes row 4 cols 0..69 = 0x00;
//     cursor (4,0); key_ready low for exactly 70 cycles.
//   3 cursor (29,10), send 0x0D -> no char write, 70 blank writes row 0, cursor (0,0).
//   4 backspace at (5,0) -> write (4,69)=0x00, cursor (4,69).
//     Backspace at (0,0) -> no write, cursor unchanged.
//   5 clear_all pulse in IDLE -> 2100 blank writes row-major, busy high 2100 cycles,
//     cursor (0,0); keys stalled (key_ready=0) throughout.
//   6 assert rst_n=0 mid CLEAR_LINE -> wr_en=0 and cursor (0,0) immediately,
//     IDLE after release, no further writes.

Source files
------------

// File: rtl/text_cursor_ctrl.sv
// rtl/text_cursor_ctrl.sv - keystroke-driven cursor tracking and sole writer of the text screen RAM
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_valid/key_ascii   keystroke stream in
//   key_ready             keystroke accepted when key_valid & key_ready at a clk edge
//   clear_all             single-cycle request to blank the whole screen and home the cursor
//   wr_en/wr_row/wr_col/wr_data   registered screen RAM write port (8'h00 = blank)
//   cur_row/cur_col       current cursor position
//   busy                  high while a line or screen clear is in progress

module text_cursor_ctrl #(
    parameter int COLS  = 70,
    parameter int ROWS  = 30,
    parameter int COL_W = 7,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [7:0]       key_ascii,
    output logic             key_ready,
    input  logic             clear_all,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR_LINE,
        S_CLEAR_ALL
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t           state;
    logic             clr_pend;
    logic [COL_W-1:0] clr_col;
    logic [ROW_W-1:0] clr_row;

    logic             accept;
    logic             printable;
    logic [ROW_W-1:0] next_row;

    assign key_ready = (state == S_IDLE) && !clr_pend;
    assign busy      = (state != S_IDLE);
    assign accept    = key_valid && key_ready;
    assign printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
    assign next_row  = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            clr_pend <= 1'b0;
            clr_col  <= '0;
            clr_row  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            wr_en    <= 1'b0;
            wr_row   <= '0;
            wr_col   <= '0;
            wr_data  <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (clear_all) begin
                clr_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            wr_en   <= 1'b1;
                            wr_row  <= cur_row;
                            wr_col  <= cur_col;
                            wr_data <= key_ascii;
                            if (cur_col == LAST_COL) begin
                                cur_col <= '0;
                                cur_row <= next_row;
                                clr_col <= '0;
                                state   <= S_CLEAR_LINE;
                            end else begin
                                cur_col <= cur_col + COL_W'(1);
                            end
                        end else if (key_ascii == 8'h0D) begin
                            cur_col <= '0;
                            cur_row <= next_row;
                            clr_col <= '0;
                            state   <= S_CLEAR_LINE;
                        end else if (key_ascii == 8'h08) begin
                            // Backspace blanks the cell it moves onto; at home it is a no-op.
                            if (cur_col != '0) begin
                                cur_col <= cur_col - COL_W'(1);
                                wr_en   <= 1'b1;
                                wr_row  <= cur_row;
                                wr_col  <= cur_col - COL_W'(1);
                                wr_data <= 8'h00;
                            end else if (cur_row != '0) begin
                                cur_row <= cur_row - ROW_W'(1);
                                cur_col <= LAST_COL;
                                wr_en   <= 1'b1;
                                wr_row  <= cur_row - ROW_W'(1);
                                wr_col  <= LAST_COL;
                                wr_data <= 8'h00;
                            end
                        end
                    end else if (clr_pend) begin
                        // A clear request landing on the entry cycle keeps the flag set,
                        // so the whole-screen clear runs once more afterwards.
                        if (!clear_all) begin
                            clr_pend <= 1'b0;
                        end
                        cur_row <= '0;
                        cur_col <= '0;
                        clr_row <= '0;
                        clr_col <= '0;
                        state   <= S_CLEAR_ALL;
                    end
                end

                S_CLEAR_LINE: begin
                    wr_en   <= 1'b1;
                    wr_row  <= cur_row;
                    wr_col  <= clr_col;
                    wr_data <= 8'h00;
                    if (clr_col == LAST_COL) begin
                        clr_col <= '0;
                        state   <= S_IDLE;
                    end else begin
                        clr_col <= clr_col + COL_W'(1);
                    end
                end

                S_CLEAR_ALL: begin
                    wr_en   <= 1'b1;
                    wr_row  <= clr_row;
                    wr_col  <= clr_col;
                    wr_data <= 8'h00;
                    if (clr_col == LAST_COL) begin
                        clr_col <= '0;
                        if (clr_row == LAST_ROW) begin
                            clr_row <= '0;
                            state   <= S_IDLE;
                        end else begin
                            clr_row <= clr_row + ROW_W'(1);
                        end
                    end else begin
                        clr_col <= clr_col + COL_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb/tb_text_cursor_ctrl.sv - scoreboard bench for text_cursor_ctrl with a screen-level reference model

module tb_text_cursor_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic       clear_all;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [6:0] wr_col;
    logic [7:0] wr_data;
    logic [4:0] cur_row;
    logic [6:0] cur_col;
    logic       busy;

    text_cursor_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .clear_all (clear_all),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_wr_cyc = -10;
    int   prev_wr_cyc = -20;
    int   m_row = 0;
    int   m_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%h expected no write", wr_row, wr_col, wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_row", int'(wr_row), e.row);
                chk("wr_col", int'(wr_col), e.col);
                chk("wr_data", int'(wr_data), e.data);
            end
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
        end
    end

    // Reference model: screen-level effects of a keystroke.
    task automatic push_wr(input int r, input int c, input int d);
        exp_t e;
        e.row = r; e.col = c; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_line(input int r);
        for (int c = 0; c < COLS; c++) push_wr(r, c, 0);
    endtask

    task automatic push_all();
        for (int r = 0; r < ROWS; r++) push_line(r);
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_key(input int a);
        if (a >= 32 && a <= 126) begin
            push_wr(m_row, m_col, a);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                push_line(m_row);
            end
        end else if (a == 13) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
            push_line(m_row);
        end else if (a == 8) begin
            if (m_col > 0 || m_row > 0) begin
                if (m_col > 0) m_col--;
                else begin m_row--; m_col = COLS - 1; end
                push_wr(m_row, m_col, 0);
            end
        end
    endtask

    task automatic send_key(input int a, input bit with_clr);
        int n = 0;
        key_ascii = 8'(a);
        key_valid = 1'b1;
        while (!key_ready && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("key_ready_timeout", 0, 1);
        if (with_clr) clear_all = 1'b1;
        model_key(a);
        @(negedge clk);
        key_valid = 1'b0;
        clear_all = 1'b0;
        chk("cur_row", int'(cur_row), m_row);
        chk("cur_col", int'(cur_col), m_col);
        if (with_clr) push_all();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!key_ready && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic do_reset();
        int n;
        wait_ready(n);
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int bad;
        int r;
        int a;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        clear_all = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_cur_row", int'(cur_row), 0);
        chk("rst_cur_col", int'(cur_col), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_key_ready", int'(key_ready), 1);

        // 'h','i' back to back
        send_key(8'h68, 0);
        chk("ready_between", int'(key_ready), 1);
        send_key(8'h69, 0);
        chk("ready_after_hi", int'(key_ready), 1);
        @(negedge clk);
        chk("hi_consecutive", last_wr_cyc - prev_wr_cyc, 1);

        // wrap at column 69 of row 3
        do_reset();
        repeat (3) send_key(8'h0D, 0);
        for (int i = 0; i < COLS - 1; i++) send_key(8'h61 + (i % 26), 0);
        send_key(8'h41, 0);
        wait_ready(n);
        chk("wrap_ready_low", n, COLS);
        chk("wrap_row", int'(cur_row), 4);
        chk("wrap_col", int'(cur_col), 0);

        // carriage return on the last row wraps to row 0
        do_reset();
        repeat (ROWS - 1) send_key(8'h0D, 0);
        for (int i = 0; i < 10; i++) send_key(8'h30 + i, 0);
        send_key(8'h0D, 0);
        wait_ready(n);
        chk("cr_wrap_row", int'(cur_row), 0);
        chk("cr_wrap_col", int'(cur_col), 0);

        // backspace across a row boundary, then at home
        do_reset();
        repeat (5) send_key(8'h0D, 0);
        wait_ready(n);
        send_key(8'h08, 0);
        chk("bs_row", int'(cur_row), 4);
        chk("bs_col", int'(cur_col), COLS - 1);
        do_reset();
        send_key(8'h08, 0);
        repeat (3) @(negedge clk);
        chk("bs_home_row", int'(cur_row), 0);
        chk("bs_home_col", int'(cur_col), 0);

        // whole-screen clear
        send_key(8'h5A, 0);
        send_key(8'h5A, 0);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        push_all();
        chk("clr_pend_stall", int'(key_ready), 0);
        @(negedge clk);
        n = 0;
        bad = 0;
        while (busy && n < 5000) begin
            if (key_ready) bad++;
            n++;
            @(negedge clk);
        end
        chk("clear_all_busy", n, ROWS * COLS);
        chk("clear_all_stall", bad, 0);
        chk("clear_all_row", int'(cur_row), 0);
        chk("clear_all_col", int'(cur_col), 0);

        // reset in the middle of a line clear
        send_key(8'h0D, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_row", int'(cur_row), 0);
        chk("midrst_col", int'(cur_col), 0);
        chk("midrst_busy", int'(busy), 0);
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("midrst_idle", int'(busy), 0);
        chk("midrst_ready", int'(key_ready), 1);

        // randomized keystrokes
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 72) a = $urandom_range(32, 126);
            else if (r < 80) a = 13;
            else if (r < 93) a = 8;
            else if (r < 98) begin
                a = $urandom_range(0, 31);
                if (a == 8 || a == 13) a = $urandom_range(127, 255);
            end else a = -1;
            if (a < 0) begin
                send_key($urandom_range(32, 126), 1);
                wait_ready(n);
                chk("rand_clr_row", int'(cur_row), 0);
                chk("rand_clr_col", int'(cur_col), 0);
            end else begin
                send_key(a, 0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_ready(n);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
